// File: rtl/button_reader_pkg.sv
// Shared types and default timing constants for the push-button reader.
// Consumers: button_reader (long-press path selected by BUTTON_READER_LONG_PRESS_EN).
package button_reader_pkg;

    localparam int CLK_HZ              = 12000000;
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
    localparam int LONG_CYCLES_DEF     = CLK_HZ;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_P     = 3'd1,
        HELD      = 3'd2,
        LONG_HELD = 3'd3,
        DEB_R     = 3'd4
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_reader_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; RST_VAL sets the
// level both flops take during reset (normally the input's idle level).
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_reader.sv
// Push-button reader: synchronize, debounce, short/long classification, blink toggle.
// Long-press detection is compiled in only when BUTTON_READER_LONG_PRESS_EN is defined.
//
// state     | meaning
// IDLE      | released, waiting for a sampled press
// DEB_P     | press seen, counting stable cycles before accepting it
// HELD      | press accepted, long timer running
// LONG_HELD | long press reported, waiting for release
// DEB_R     | release seen, counting stable cycles before accepting it
module button_reader
    import button_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk_12Mhz,
    input  logic rst,
    input  logic btn_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic blink_enable
);

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_DEB_P     = DEB_P;
    localparam logic [2:0] S_HELD      = HELD;
    localparam logic [2:0] S_DEB_R     = DEB_R;
`ifdef BUTTON_READER_LONG_PRESS_EN
    localparam logic [2:0] S_LONG_HELD = LONG_HELD;
    localparam int CNT_MAX = max_int(DEBOUNCE_CYCLES, LONG_CYCLES);
`else
    localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef BUTTON_READER_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`endif

    logic btn_sync;
    logic s;

    sync_2ff #(
        .RST_VAL((ACTIVE_LOW != 0) ? 1'b1 : 1'b0)
    ) u_sync (
        .clk (clk_12Mhz),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_sync)
    );

    assign s = (ACTIVE_LOW != 0) ? ~btn_sync : btn_sync;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             blink_q, blink_d;
`ifdef BUTTON_READER_LONG_PRESS_EN
    logic             long_q, long_d;
    logic             long_seen_q, long_seen_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        blink_d   = blink_q;
`ifdef BUTTON_READER_LONG_PRESS_EN
        long_d      = 1'b0;
        long_seen_d = long_seen_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (s) begin
                    state_d = S_DEB_P;
                    cnt_d   = '0;
                end
            end
            S_DEB_P: begin
                if (!s) begin
                    state_d = S_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_HELD;
                    press_d = 1'b1;
                    cnt_d   = '0;
`ifdef BUTTON_READER_LONG_PRESS_EN
                    long_seen_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HELD: begin
                if (!s) begin
                    state_d = S_DEB_R;
                    cnt_d   = '0;
                end
`ifdef BUTTON_READER_LONG_PRESS_EN
                else if (cnt_q == LONG_LAST) begin
                    state_d     = S_LONG_HELD;
                    long_d      = 1'b1;
                    long_seen_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
`endif
            end
`ifdef BUTTON_READER_LONG_PRESS_EN
            S_LONG_HELD: begin
                if (!s) begin
                    state_d = S_DEB_R;
                    cnt_d   = '0;
                end
            end
`endif
            S_DEB_R: begin
                if (s) begin
                    // A release bounce restarts the long timer from zero.
`ifdef BUTTON_READER_LONG_PRESS_EN
                    state_d = long_seen_q ? S_LONG_HELD : S_HELD;
`else
                    state_d = S_HELD;
`endif
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
`ifdef BUTTON_READER_LONG_PRESS_EN
                    if (!long_seen_q) begin
                        short_d = 1'b1;
                        blink_d = ~blink_q;
                    end
`else
                    short_d = 1'b1;
                    blink_d = ~blink_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef BUTTON_READER_LONG_PRESS_EN
        pressed_d = (state_d == S_HELD) || (state_d == S_LONG_HELD) || (state_d == S_DEB_R);
`else
        pressed_d = (state_d == S_HELD) || (state_d == S_DEB_R);
`endif
    end

    always_ff @(posedge clk_12Mhz or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            blink_q   <= blink_d;
        end
    end

`ifdef BUTTON_READER_LONG_PRESS_EN
    always_ff @(posedge clk_12Mhz or posedge rst) begin
        if (rst) begin
            long_q      <= 1'b0;
            long_seen_q <= 1'b0;
        end else begin
            long_q      <= long_d;
            long_seen_q <= long_seen_d;
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign blink_enable  = blink_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed + random bench for button_reader against a run-length reference model
// (long-press expectations follow BUTTON_READER_LONG_PRESS_EN).
module tb_button_reader;

    localparam int DEB  = 4;
    localparam int LONG = 20;
`ifdef BUTTON_READER_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk_12Mhz = 1'b0;
    logic rst;
    logic btn_raw;
    logic pressed, press_pulse, release_pulse, short_pulse, long_pulse, blink_enable;

    bit btn;                       // 1 = button physically pressed
    assign btn_raw = ~btn;         // pull-up board: pin reads 0 when pressed

    button_reader #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk_12Mhz    (clk_12Mhz),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .blink_enable (blink_enable)
    );

    always #5 clk_12Mhz = ~clk_12Mhz;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pin history plus run lengths of the synchronized level.
    bit h0, h1;
    bit m_acc, m_seen, m_blink;
    bit m_press, m_rel, m_short, m_long;
    int m_run, m_hold;

    task automatic model_reset();
        h0 = 0; h1 = 0;
        m_acc = 0; m_seen = 0; m_blink = 0;
        m_press = 0; m_rel = 0; m_short = 0; m_long = 0;
        m_run = 0; m_hold = 0;
    endtask

    task automatic model_edge();
        bit s;
        s  = h1;
        h1 = h0;
        h0 = btn;
        m_press = 0; m_rel = 0; m_short = 0; m_long = 0;
        if (s != m_acc) begin
            // a new level is accepted once it has been seen on DEB+1 consecutive edges
            m_run++;
            if (m_run == DEB + 1) begin
                m_acc = s;
                m_run = 0;
                if (s) begin
                    m_press = 1; m_hold = 0; m_seen = 0;
                end else begin
                    m_rel = 1;
                    if (!LONG_EN || !m_seen) begin
                        m_short = 1;
                        m_blink = ~m_blink;
                    end
                end
            end
        end else begin
            if (m_run > 0) m_hold = 0;
            else if (m_acc) begin
                m_hold++;
                if (LONG_EN && !m_seen && m_hold == LONG) begin
                    m_long = 1;
                    m_seen = 1;
                end
            end
            m_run = 0;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pressed"},       pressed,       m_acc);
        chk({tag, ".press_pulse"},   press_pulse,   m_press);
        chk({tag, ".release_pulse"}, release_pulse, m_rel);
        chk({tag, ".short_pulse"},   short_pulse,   m_short);
        chk({tag, ".long_pulse"},    long_pulse,    m_long);
        chk({tag, ".blink_enable"},  blink_enable,  m_blink);
    endtask

    task automatic tick();
        @(posedge clk_12Mhz);
        model_edge();
        #1;
        check_all("cycle");
        @(negedge clk_12Mhz);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        @(negedge clk_12Mhz);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk_12Mhz);
        @(negedge clk_12Mhz);
        rst = 1'b0;
    endtask

    int lat, press_cyc, long_cyc, n_long, n_rel, n_short, n_evt, len;

    initial begin
        rst = 1'b0;
        btn = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        #1 check_all("por");
        @(negedge clk_12Mhz);
        @(negedge clk_12Mhz);
        rst = 1'b0;
        idle(5);

        // clean press: edge 0 samples the press, pulse visible after edge DEB+2
        btn = 1; lat = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (press_pulse === 1'b1 && lat < 0) lat = i;
        end
        chk_int("press_latency", lat, DEB + 2);
        chk("pressed_after_press", pressed, 1'b1);

        // short press release
        btn = 0; lat = -1; n_short = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (release_pulse === 1'b1 && lat < 0) lat = i;
            if (short_pulse === 1'b1) n_short++;
        end
        chk_int("release_latency", lat, DEB + 2);
        chk_int("short_count", n_short, 1);
        chk("blink_after_short", blink_enable, 1'b1);

        // bounce from IDLE: toggle every 2 cycles
        n_evt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) btn = ~btn;
            tick();
            if (pressed || press_pulse || release_pulse || short_pulse || long_pulse) n_evt++;
        end
        chk_int("bounce_quiet", n_evt, 0);
        btn = 0;
        idle(8);

        // long press
        btn = 1; press_cyc = -1; long_cyc = -1; n_long = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (press_pulse === 1'b1) press_cyc = i;
            if (long_pulse === 1'b1) begin
                n_long++;
                if (long_cyc < 0) long_cyc = i;
            end
        end
        chk_int("long_count", n_long, LONG_EN ? 1 : 0);
        if (LONG_EN) chk_int("long_latency", long_cyc - press_cyc, LONG);

        // 2-cycle release glitch while held
        btn = 0; tick(); tick();
        btn = 1; n_long = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (long_pulse === 1'b1) n_long++;
        end
        chk_int("glitch_no_second_long", n_long, 0);
        chk("glitch_still_pressed", pressed, 1'b1);

        // release after long hold
        btn = 0; n_rel = 0; n_short = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (release_pulse === 1'b1) n_rel++;
            if (short_pulse === 1'b1) n_short++;
        end
        chk_int("long_release_count", n_rel, 1);
        chk_int("long_release_short", n_short, LONG_EN ? 0 : 1);
        chk("blink_after_long", blink_enable, LONG_EN ? 1'b1 : 1'b0);

        if (!LONG_EN) begin
            btn = 1; idle(12);
            btn = 0; idle(12);
        end

        // reset while held with blink_enable set
        btn = 1; idle(10);
        chk("pre_reset_blink", blink_enable, 1'b1);
        chk("pre_reset_pressed", pressed, 1'b1);
        do_reset();
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (press_pulse === 1'b1 && lat < 0) lat = i;
        end
        chk_int("press_after_reset", lat, DEB + 2);
        btn = 0; idle(12);

        // random pin activity
        for (int seg = 0; seg < 40; seg++) begin
            btn = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                              : int'($urandom_range(1, 7));
            idle(len);
        end
        btn = 0;
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/button_reader.md
# button_reader

Input-side companion to the RGB LED blinker: reads one raw board push-button on the 12 MHz domain, synchronizes and debounces it, classifies presses as short or long, and produces a registered `blink_enable` level. It sits between the board pin and the LED blinker's `blink_enable` input, and also exposes one-cycle event pulses for other consumers.

## Interface
- `DEBOUNCE_CYCLES`, 120000, cycles the synchronized input must be stable to accept a change (10 ms at 12 MHz); legal range ≥2.
- `LONG_CYCLES`, 12000000, cycles held (after press accepted) to classify a long press (1 s); legal range ≥2.
- `ACTIVE_LOW`, 1, 1 = pin reads 0 when pressed (pull-up board button), 0 = pin reads 1 when pressed.
- `clk_12Mhz` input 1 system clock, all logic on rising edge.
- `rst` input 1 asynchronous, active-high reset.
- `btn_raw` input 1 raw, asynchronous pin.
- `pressed` output 1 debounced level, high while press is accepted.
- `press_pulse` output 1 one cycle on accepted press.
- `release_pulse` output 1 one cycle on accepted release.
- `short_pulse` output 1 one cycle on release of a press that never reached long.
- `long_pulse` output 1 one cycle when hold reaches `LONG_CYCLES`.
- `blink_enable` output 1 level, toggles on every `short_pulse`.

## Operation
- `btn_raw` passes through a 2-flop synchronizer and is polarity-normalized to `s` (1 = pressed). Synchronizer flops reset to the released level.
- One shared counter (width `$clog2` of the larger of `DEBOUNCE_CYCLES` and `LONG_CYCLES`) plus a `long_seen` flag.
- States:
  - `IDLE`: if `s`, go to `DEB_P`, and the counter is set to 0.
  - `DEB_P`: if `!s`, go to `IDLE` (bounce). Else if counter == `DEBOUNCE_CYCLES-1`, go to `HELD` and assert `press_pulse`; the counter is cleared and `long_seen` is set to 0. Else the counter increments.
  - `HELD`: if `!s`, go to `DEB_R`, and the counter is set to 0. Else if counter == `LONG_CYCLES-1`, go to `LONG_HELD`, assert `long_pulse` and set `long_seen` to 1. Else the counter increments.
  - `LONG_HELD`: if `!s`, go to `DEB_R`, and the counter is set to 0. Otherwise hold; the counter does not advance.
  - `DEB_R`: if `s`, return to `LONG_HELD` when `long_seen` is set, else to `HELD`. On that return the counter is cleared, so the long timer restarts. Else if counter == `DEBOUNCE_CYCLES-1`, go to `IDLE` and assert `release_pulse`. If `!long_seen`, also assert `short_pulse` and toggle `blink_enable`.
- `pressed` = state ∈ {`HELD`, `LONG_HELD`, `DEB_R`}, registered.
- All pulses are registered, exactly one cycle wide, and never asserted in the same cycle as each other except `release_pulse`+`short_pulse`.
- `long_pulse` fires at most once per accepted press.

## Timing
- Reset (async assert, sync-free release): state `IDLE`, counter 0, `long_seen` 0. Every output is 0, including `blink_enable`.
- Press latency: counting the edge that first samples `btn_raw` pressed as edge 0, `press_pulse` and `pressed` are high after edge `DEBOUNCE_CYCLES+2`, with no bounce.
- Release latency is identical: `release_pulse` comes `DEBOUNCE_CYCLES+2` edges after the sampled release, and `pressed` falls in the same cycle.
- `long_pulse` comes `LONG_CYCLES` edges after `press_pulse`.
- Any glitch shorter than `DEBOUNCE_CYCLES` cycles that starts in `IDLE` or `HELD` produces no output change.
- Reset mid-press clears everything. If the button is still held after reset deasserts, it is treated as a new press: full debounce, then `press_pulse`.

## Configuration
- `BUTTON_READER_LONG_PRESS_EN` defined:
  - Long-press path as above.
- Not defined:
  - `LONG_HELD` and `long_seen` are removed.
  - `HELD` only watches for release.
  - `long_pulse` is tied to 0.
  - Every accepted release asserts `short_pulse` and toggles `blink_enable`.
  - The counter is sized from `DEBOUNCE_CYCLES` only.

## Structure
- `button_reader_pkg`: state enum (`IDLE`, `DEB_P`, `HELD`, `LONG_HELD`, `DEB_R`); default constants `CLK_HZ=12000000`, `DEBOUNCE_CYCLES_DEF`, `LONG_CYCLES_DEF`.
- Sub-module `sync_2ff`: 2-flop synchronizer with reset-value parameter, reusable for other board inputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `LONG_CYCLES=20`, `ACTIVE_LOW=1`, with the macro defined unless noted.
- Clean press: `btn_raw` 1→0 sampled at edge 0 → `press_pulse`=1 for one cycle after edge 6, `pressed`=1.
- Short press: release after 10 cycles held → `release_pulse` and `short_pulse` together after the 6th edge after the release. `blink_enable` goes 0→1, and `long_pulse` never fires.
- Bounce: toggle `btn_raw` every 2 cycles for 30 cycles from `IDLE` → no pulses, and `pressed` stays 0.
- Long press: hold 40 cycles → `long_pulse` 20 edges after `press_pulse`, once only. On release, `release_pulse` fires with no `short_pulse`, and `blink_enable` is unchanged.
- Release bounce after long: 2-cycle release glitch in `LONG_HELD` → return to `LONG_HELD`, no second `long_pulse`.
- Reset mid-press: assert `rst` while in `HELD` with `blink_enable`=1 → all outputs 0 immediately. With the button still held after deassert → `press_pulse` 6 edges later. With the macro undefined, a 40-cycle hold gives `long_pulse`=0 and `short_pulse` on release.
